// File: rtl/branch_pkg.sv
// Shared types and constants for the branch predictor: counter encodings and BTB entry layout.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package branch_pkg;

  localparam int PC_W  = 8;
  localparam int IDX_W = 3;
  localparam int CNT_W = 16;
  localparam int TAG_W = PC_W - IDX_W - 2;

  // 2-bit direction counter; the MSB is the taken/not-taken prediction.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  localparam ctr_e CTR_INIT  = WNT;
  localparam ctr_e CTR_ALLOC = WT;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  target;
    ctr_e             ctr;
  } btb_entry_t;

endpackage

// File: rtl/sat_ctr2.sv
// Next state of a 2-bit saturating direction counter given the resolved direction.
// Latency: combinational, 0 cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   ctr      current counter state
//   taken    resolved branch direction
//   ctr_next saturating increment when taken, saturating decrement otherwise
module sat_ctr2
  import branch_pkg::*;
(
  input  ctr_e ctr,
  input  logic taken,
  output ctr_e ctr_next
);

  always_comb begin
    ctr_next = ctr;
    case (ctr)
      SNT:     ctr_next = taken ? WNT : SNT;
      WNT:     ctr_next = taken ? WT  : SNT;
      WT:      ctr_next = taken ? ST  : WNT;
      ST:      ctr_next = taken ? ST  : WT;
      default: ctr_next = CTR_INIT;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters, trained from ID-stage resolution, plus perf counters.
// Latency: lookup and mispredict are combinational (0 cycles); training/counters take effect next edge.
// Backpressure: stall freezes table and counters and masks mispredict; lookup stays live.
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   stall                            pipeline stall
//   fetch_pc -> pred_taken/target    IF-stage lookup
//   upd_*                            resolved branch from ID (pc, direction, target, carried prediction)
//   mispredict                       carried prediction disagrees with the resolution
//   branch_cnt, mispred_cnt          saturating performance counters
//
// The entry layout comes from branch_pkg, so PC_W/IDX_W must match the package values.
module branch_predictor
  import branch_pkg::*;
#(
  parameter int PC_W  = branch_pkg::PC_W,
  parameter int IDX_W = branch_pkg::IDX_W,
  parameter int CNT_W = branch_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [PC_W-1:0]  fetch_pc,
  output logic             pred_taken,
  output logic [PC_W-1:0]  pred_target,
  input  logic             upd_valid,
  input  logic [PC_W-1:0]  upd_pc,
  input  logic             upd_taken,
  input  logic [PC_W-1:0]  upd_target,
  input  logic             upd_pred_taken,
  input  logic [PC_W-1:0]  upd_pred_target,
  output logic             mispredict,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int ENTRIES = 2 ** IDX_W;
  localparam int TAG_W   = PC_W - IDX_W - 2;

  btb_entry_t btb [ENTRIES];

  logic [IDX_W-1:0] fetch_idx, upd_idx;
  logic [TAG_W-1:0] fetch_tag, upd_tag;
  btb_entry_t       fetch_ent, upd_ent;
  logic             fetch_hit, upd_hit;
  logic             do_upd;
  ctr_e             ctr_next;

  // Word-aligned PCs: the two LSBs never reach the index or tag.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{fetch_pc[1:0], upd_pc[1:0]};

  assign fetch_idx = fetch_pc[IDX_W+1:2];
  assign fetch_tag = fetch_pc[PC_W-1:IDX_W+2];
  assign upd_idx   = upd_pc[IDX_W+1:2];
  assign upd_tag   = upd_pc[PC_W-1:IDX_W+2];

  // Lookup reads the registered table, so a same-index update this cycle is not visible yet.
  assign fetch_ent = btb[fetch_idx];
  assign fetch_hit = fetch_ent.valid && (fetch_ent.tag == fetch_tag);

  assign pred_taken  = fetch_hit && fetch_ent.ctr[1];
  assign pred_target = pred_taken ? fetch_ent.target : fetch_pc + PC_W'(4);

  assign upd_ent = btb[upd_idx];
  assign upd_hit = upd_ent.valid && (upd_ent.tag == upd_tag);
  assign do_upd  = upd_valid && !stall;

  // A not-taken branch predicted not-taken is correct whatever the carried target was.
  assign mispredict = do_upd &&
                      ((upd_pred_taken != upd_taken) ||
                       (upd_taken && (upd_pred_target != upd_target)));

  sat_ctr2 u_sat_ctr2 (
    .ctr      (upd_ent.ctr),
    .taken    (upd_taken),
    .ctr_next (ctr_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb[i].valid  <= 1'b0;
        btb[i].tag    <= '0;
        btb[i].target <= '0;
        btb[i].ctr    <= CTR_INIT;
      end
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else if (do_upd) begin
      if (upd_hit) begin
        btb[upd_idx].ctr <= ctr_next;
        if (upd_taken) begin
          btb[upd_idx].target <= upd_target;
        end
      end else if (upd_taken) begin
        // Miss on a taken branch replaces whatever occupied the slot.
        btb[upd_idx].valid  <= 1'b1;
        btb[upd_idx].tag    <= upd_tag;
        btb[upd_idx].target <= upd_target;
        btb[upd_idx].ctr    <= CTR_ALLOC;
      end

      if (branch_cnt != '1) begin
        branch_cnt <= branch_cnt + CNT_W'(1);
      end
      if (mispredict && (mispred_cnt != '1)) begin
        mispred_cnt <= mispred_cnt + CNT_W'(1);
      end
    end
  end

endmodule
